// File: rtl/layer5_argmax.sv
// Collects N_CLASS finish-qualified class scores, then scans them for the signed maximum.
// Optional sticky overrun flag for fins dropped while scanning: define LAYER5_OVERRUN_CHK_EN.
//
// state   | meaning
// COLLECT | latching per-PE scores until every got bit is set
// SCAN    | one comparison per cycle, result published on the last one
module layer5_argmax #(
  parameter int N_CLASS = 10,
  parameter int DW      = 18,
  parameter int CW      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CLASS*DW-1:0] din,
  input  logic [N_CLASS-1:0]    fin,
  output logic [CW-1:0]         class_idx,
  output logic signed [DW-1:0]  max_score,
  output logic                  valid,
  output logic                  busy
`ifdef LAYER5_OVERRUN_CHK_EN
  ,
  output logic                  overrun
`endif
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] SCAN    = 1'b1;

  logic [0:0]           state;
  logic signed [DW-1:0] score [N_CLASS];
  logic [N_CLASS-1:0]   got;
  logic [CW-1:0]        ptr;
  logic [CW-1:0]        best_idx;
  logic signed [DW-1:0] best;
  logic signed [DW-1:0] cur;
  logic signed [DW-1:0] nxt_best;
  logic [CW-1:0]        nxt_idx;
  logic                 all_got;
  logic                 last;

  assign all_got = &got;
  assign busy    = (state == SCAN);
  assign last    = (ptr == CW'(N_CLASS - 1));

  always_comb begin
    cur = '0;
    for (int i = 0; i < N_CLASS; i++) begin
      if (ptr == CW'(i)) cur = score[i];
    end
  end

  // Strict greater-than so ties keep the lower index.
  always_comb begin
    nxt_best = best;
    nxt_idx  = best_idx;
    if (cur > best) begin
      nxt_best = cur;
      nxt_idx  = ptr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= COLLECT;
      got       <= '0;
      ptr       <= '0;
      best      <= '0;
      best_idx  <= '0;
      class_idx <= '0;
      max_score <= '0;
      valid     <= 1'b0;
      for (int i = 0; i < N_CLASS; i++) score[i] <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        COLLECT: begin
          // Fins arriving on the transition edge are dropped along with SCAN-time fins.
          if (all_got) begin
            state    <= SCAN;
            best     <= score[0];
            best_idx <= '0;
            ptr      <= CW'(1);
          end else begin
            for (int i = 0; i < N_CLASS; i++) begin
              if (fin[i]) begin
                score[i] <= din[i*DW +: DW];
                got[i]   <= 1'b1;
              end
            end
          end
        end
        SCAN: begin
          best     <= nxt_best;
          best_idx <= nxt_idx;
          ptr      <= ptr + CW'(1);
          if (last) begin
            class_idx <= nxt_idx;
            max_score <= nxt_best;
            valid     <= 1'b1;
            got       <= '0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef LAYER5_OVERRUN_CHK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun <= 1'b0;
    else if (|fin && (state == SCAN || all_got)) overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_layer5_argmax.sv
// Directed bench for layer5_argmax: per-cycle compare against a behavioural argmax model
// plus literal expectations for each directed image.
module tb_layer5_argmax;
  localparam int N  = 10;
  localparam int DW = 18;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*DW-1:0]   din;
  logic [N-1:0]      fin;
  logic [CW-1:0]     class_idx;
  logic signed [DW-1:0] max_score;
  logic              valid;
  logic              busy;
`ifdef LAYER5_OVERRUN_CHK_EN
  logic              overrun;
`endif

  layer5_argmax #(.N_CLASS(N), .DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .fin       (fin),
    .class_idx (class_idx),
    .max_score (max_score),
    .valid     (valid),
    .busy      (busy)
`ifdef LAYER5_OVERRUN_CHK_EN
    ,
    .overrun   (overrun)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: scores/got set, edge count since scan start, argmax by plain loop.
  int       m_s [N];
  logic [N-1:0] m_got;
  int       cnt, p_idx, p_max, e_idx, e_max;
  bit       e_valid, e_ovr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_got = '0; cnt = 0; e_valid = 0; e_idx = 0; e_max = 0; e_ovr = 0;
      p_idx = 0; p_max = 0;
      for (int i = 0; i < N; i++) m_s[i] = 0;
    end else begin
      e_valid = 0;
      if (cnt == 0) begin
        if (&m_got) begin
          cnt = 1;
          if (|fin) e_ovr = 1;
          p_idx = 0; p_max = m_s[0];
          for (int i = 1; i < N; i++)
            if (m_s[i] > p_max) begin p_max = m_s[i]; p_idx = i; end
        end else begin
          for (int i = 0; i < N; i++)
            if (fin[i]) begin m_s[i] = $signed(din[i*DW +: DW]); m_got[i] = 1'b1; end
        end
      end else begin
        if (|fin) e_ovr = 1;
        cnt++;
        if (cnt == N) begin
          e_idx = p_idx; e_max = p_max; e_valid = 1; m_got = '0; cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("valid", valid, e_valid);
      check("busy", busy, int'(cnt != 0));
      check("class_idx", class_idx, e_idx);
      check("max_score", max_score, e_max);
`ifdef LAYER5_OVERRUN_CHK_EN
      check("overrun", overrun, e_ovr);
`endif
    end
  end

  task automatic load(input int v [N]);
    for (int i = 0; i < N; i++) din[i*DW +: DW] = DW'(v[i]);
  endtask

  task automatic send(input logic [N-1:0] f);
    @(negedge clk); fin = f;
    @(negedge clk); fin = '0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    bit seen;
    seen = 0; n = 0;
    while (!seen && n < budget) begin
      @(negedge clk); n++;
      if (valid) seen = 1;
    end
    if (!seen) begin
      fails++; tests++;
      $display("FAIL valid_timeout: no valid within %0d cycles, expected a pulse", budget);
    end
  endtask

  int vals [N];
  int n;

  initial begin
    reset = 1'b1; fin = '0; din = '0;
    repeat (2) @(negedge clk);
    check("rst_class_idx", class_idx, 0);
    check("rst_max_score", max_score, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // Image 1: tie between idx 2 and 4 at 100.
    vals = '{5, -3, 100, 7, 100, 0, -200, 99, 1, 2};
    load(vals);
    send(10'h3FF);
    wait_valid(30, n);
    check("t1_latency", n, 10);
    check("t1_class_idx", class_idx, 2);
    check("t1_max_score", max_score, 100);

    // Staggered fins, all negative except idx 7 = -1.
    for (int i = 0; i < N; i++) vals[i] = -50 + i;
    vals[7] = -1;
    load(vals);
    @(negedge clk); fin = 10'h200;
    for (int i = 0; i < N - 1; i++) begin
      @(negedge clk);
      check("stag_busy", busy, 0);
      fin = N'(1) << i;
    end
    @(negedge clk); fin = '0;
    wait_valid(30, n);
    check("t2_latency", n, 10);
    check("t2_class_idx", class_idx, 7);
    check("t2_max_score", max_score, -1);

    // Duplicate fin[3]: later value wins.
    for (int i = 0; i < N; i++) vals[i] = 0;
    vals[3] = 10;
    load(vals);
    send(10'h008);
    din[3*DW +: DW] = DW'(500);
    send(10'h008);
    send(10'h3F7);
    wait_valid(30, n);
    check("t3_class_idx", class_idx, 3);
    check("t3_max_score", max_score, 500);

    // Asynchronous reset mid-scan.
    vals = '{5, -3, 100, 7, 100, 0, -200, 99, 1, 2};
    load(vals);
    send(10'h3FF);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_class_idx", class_idx, 0);
    check("arst_max_score", max_score, 0);
    check("arst_busy", busy, 0);
    check("arst_valid", valid, 0);
    @(negedge clk); reset = 1'b0;
    repeat (12) @(negedge clk);

    // Extremes; first nine fins must not start a scan after the reset.
    for (int i = 0; i < N; i++) vals[i] = 0;
    vals[5] = 131071;
    vals[0] = -131072;
    load(vals);
    send(10'h3FE);
    repeat (3) @(negedge clk);
    check("ext_wait_busy", busy, 0);
    send(10'h001);
    wait_valid(30, n);
    check("t6_class_idx", class_idx, 5);
    check("t6_max_score", max_score, 131071);

    // Fin during SCAN is dropped.
    for (int i = 0; i < N; i++) vals[i] = i * 10;
    load(vals);
    send(10'h3FF);
    repeat (3) @(negedge clk);
    din[0 +: DW] = DW'(1000);
    fin = 10'h001;
    @(negedge clk); fin = '0;
    wait_valid(30, n);
    check("t4_class_idx", class_idx, 9);
    check("t4_max_score", max_score, 90);
`ifdef LAYER5_OVERRUN_CHK_EN
    check("t4_overrun", overrun, 1);
`endif
    for (int i = 0; i < N; i++) vals[i] = 3;
    vals[0] = 7;
    load(vals);
    send(10'h3FE);
    repeat (4) @(negedge clk);
    check("t4_refill_busy", busy, 0);
    send(10'h001);
    wait_valid(30, n);
    check("t4b_class_idx", class_idx, 0);
    check("t4b_max_score", max_score, 7);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/layer5_argmax.md
# layer5_argmax

Downstream stage of the final fully-connected layer. Collects the ten 18-bit class scores produced by the layer-5 PE array, one finish-qualified score per PE. Once all ten are present, scans them sequentially and reports the index and value of the maximum as the network's classification result. Provides a single-cycle valid strobe per image for the top-level controller.

## Interface

Parameters:
- N_CLASS, 10: number of class scores/PEs.
- DW, 18: score width, signed two's complement.
- CW, 4: class index width; must satisfy 2^CW ≥ N_CLASS.

Ports:
- clk, input, 1: single clock; all state updates on posedge clk.
- reset, input, 1: asynchronous, active-high; clears all state.
- din, input, N_CLASS*DW: packed scores; PE i occupies bits [i*DW +: DW].
- fin, input, N_CLASS: per-PE finish pulse; fin[i]=1 means din slice i is valid this cycle.
- class_idx, output, CW: index of the maximum score for the last completed image.
- max_score, output, DW (signed): value of that maximum.
- valid, output, 1: one-cycle pulse when class_idx/max_score update.
- busy, output, 1: high while in SCAN.
- overrun, output, 1: sticky error flag. Present only with LAYER5_OVERRUN_CHK_EN.

## Operation

- State machine with two states: COLLECT (reset state) and SCAN.
- Storage: score[N_CLASS] (DW each); got[N_CLASS] flags; ptr (CW); best (DW); best_idx (CW).

COLLECT:
- For each i with fin[i]=1, latch score[i]=din slice i and set got[i].
- Multiple fins in one cycle are all captured.
- A repeat fin[i] overwrites score[i] (latest wins).
- When got is all-ones at a clock edge, the next edge moves to SCAN and loads best=score[0], best_idx=0, ptr=1.

SCAN:
- Each cycle compares signed score[ptr] > best (strict). On true: best=score[ptr], best_idx=ptr. Then ptr increments.
- Ties keep the lower index.
- On the edge that processes ptr=N_CLASS-1:
  - class_idx and max_score take the final result (including that comparison).
  - valid=1 for the following cycle.
  - got is cleared to 0.
  - State returns to COLLECT.
- fin pulses received while in SCAN are dropped, and score is not modified.
- class_idx and max_score hold until the next completed scan.
- Reset mid-scan: all state aborts to COLLECT with got=0 and outputs zeroed. No valid is emitted.

## Timing

- Reset values: class_idx=0, max_score=0, valid=0, busy=0, overrun=0; got=0; state=COLLECT.
- Let E0 be the edge that sets the last got bit.
  - E1: enters SCAN; busy=1 from E1.
  - E1+k (k=1..N_CLASS-1): compares score[k].
  - E(N_CLASS): outputs update, valid=1 and busy=0 for the cycle after that edge.
- With N_CLASS=10: valid is high in the cycle following E10, i.e. 10 edges after E0.
- The next image's fins are accepted starting with the edge after valid rises (E11 onward). A fin on E10 itself is dropped.
- No backpressure: valid is a strobe, not a handshake. The consumer must sample it in that cycle.

## Configuration

- LAYER5_OVERRUN_CHK_EN defined:
  - overrun port exists.
  - Any fin bit high on an edge where state=SCAN, or on the edge that transitions COLLECT→SCAN, sets overrun=1 at that edge.
  - Sticky; cleared only by reset.
  - Data is still dropped.
- Undefined: no overrun port or logic; dropped fins are silent.

## Test plan

- Reset then single image: fin=10'h3FF in one cycle with scores 5,-3,100,7,100,0,-200,99,1,2 → valid pulse 10 edges later; class_idx=2, max_score=100 (tie with idx 4 resolves low).
- Staggered fins: fin[9] first, then fin[0..8] one per cycle, all scores negative (-50..-41 with idx 7 = -1) → no SCAN until the last fin; class_idx=7, max_score=-1 (signed compare).
- Duplicate fin: fin[3] with 10, later fin[3] with 500 before completion, others 0 → class_idx=3, max_score=500.
- Fin during SCAN: pulse fin[0] with 1000 three cycles into SCAN → result unaffected; next image needs all ten fins again. overrun=1 if LAYER5_OVERRUN_CHK_EN is defined.
- Reset asserted asynchronously mid-SCAN → outputs 0 immediately, no valid; a following full image produces a correct result.
- Extremes: score[5]=18'h1FFFF (max positive), score[0]=18'h20000 (min negative) → class_idx=5, max_score=131071.
